mmg_frame_ctrl: RTL and testbench

Frame-level controller for the motion map generator. It gates the incoming pixel stream into the generator and decides, frame by frame, whether the generator learns a background or detects motion. It programs the generator's threshold at frame boundaries and reduces the generator's per-pixel motion flags into per-frame results and a debounced alarm. It sits between the camera pixel source and the motion map generator, with software-visible config/status on the other side.

---
 rtl/mmg_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mmg_frame_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmg_frame_ctrl.sv
// mmg_frame_ctrl: frame-level controller for the motion map generator.
// Gates the pixel stream into the generator, picks learn or detect per frame,
// programs the generator threshold at frame boundaries, and turns per-pixel
// motion flags into per-frame results and a debounced alarm.
module mmg_frame_ctrl #(
  parameter int         MMG_LAT           = 2,
  parameter logic [7:0] DEFAULT_THRESHOLD = 8'd20,
  parameter int         FRAME_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [7:0]             cfg_threshold,
  input  logic [7:0]             cfg_bg_period,
  input  logic [3:0]             cfg_alarm_frames,
  input  logic                   s_valid,
  input  logic [31:0]            s_pixel,
  input  logic                   s_last,
  output logic                   mmg_enable,
  output logic [31:0]            mmg_pixel,
  output logic                   mmg_last_in_frame,
  output logic                   mmg_wr_background,
  output logic [7:0]             mmg_threshold,
  input  logic                   mmg_motion_detected,
  output logic                   frame_done,
  output logic                   frame_motion,
  output logic                   alarm,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LEARN  = 2'd2,
    ST_DETECT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic                   stopPending_q, stopPending_d;
  logic [7:0]             bgAge_q, bgAge_d;
  logic [7:0]             thrShadow_q, thrShadow_d;

  // Delay pipe tracking each forwarded pixel until its motion flag returns.
  logic [MMG_LAT-1:0]     pipeValid_q;
  logic [MMG_LAT-1:0]     pipeLast_q;
  logic [MMG_LAT-1:0]     pipeDetect_q;

  logic                   sticky_q, sticky_d;
  logic [3:0]             runCnt_q, runCnt_d;
  logic                   frameDone_q, frameDone_d;
  logic                   frameMotion_q, frameMotion_d;
  logic                   alarm_q, alarm_d;
  logic [FRAME_CNT_W-1:0] frameCount_q, frameCount_d;

  logic                   fwdActive;
  logic                   fwdLast;
  logic                   pipeOutValid;
  logic                   pipeOutLast;
  logic                   pipeOutDetect;
  logic                   frameClose;
  logic                   motionNow;

  assign fwdActive         = (state_q == ST_LEARN) || (state_q == ST_DETECT);
  assign mmg_enable        = s_valid & fwdActive;
  assign mmg_pixel         = s_pixel;
  assign mmg_last_in_frame = s_last & mmg_enable;
  assign mmg_wr_background = (state_q == ST_LEARN) & mmg_enable;
  assign mmg_threshold     = thrShadow_q;
  assign fwdLast           = mmg_last_in_frame;

  assign pipeOutValid  = pipeValid_q[MMG_LAT-1];
  assign pipeOutLast   = pipeLast_q[MMG_LAT-1];
  assign pipeOutDetect = pipeDetect_q[MMG_LAT-1];
  assign frameClose    = pipeOutValid & pipeOutLast;
  assign motionNow     = sticky_q | mmg_motion_detected;

  assign frame_done   = frameDone_q;
  assign frame_motion = frameMotion_q;
  assign alarm        = alarm_q;
  assign frame_count  = frameCount_q;
  assign busy         = (state_q != ST_IDLE) || (|pipeValid_q);

  // Frame sequencing: mode selection, pending stop, background age, threshold.
  always_comb begin
    state_d       = state_q;
    stopPending_d = stopPending_q;
    bgAge_d       = bgAge_q;
    thrShadow_d   = thrShadow_q;
    case (state_q)
      ST_IDLE: begin
        stopPending_d = 1'b0;
        if (start && !stop) begin
          state_d     = ST_SYNC;
          thrShadow_d = cfg_threshold;
        end
      end
      ST_SYNC: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (s_valid && s_last) begin
          state_d = ST_LEARN;
        end
      end
      ST_LEARN: begin
        if (stop) begin
          stopPending_d = 1'b1;
        end
        if (fwdLast) begin
          thrShadow_d = cfg_threshold;
          bgAge_d     = 8'd0;
          state_d     = (stopPending_q || stop) ? ST_IDLE : ST_DETECT;
        end
      end
      ST_DETECT: begin
        if (stop) begin
          stopPending_d = 1'b1;
        end
        if (fwdLast) begin
          thrShadow_d = cfg_threshold;
          bgAge_d     = bgAge_q + 8'd1;
          if (stopPending_q || stop) begin
            state_d = ST_IDLE;
          end else if ((cfg_bg_period != 8'd0) && (bgAge_d == cfg_bg_period)) begin
            state_d = ST_LEARN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-frame result reduction at the pipe output.
  always_comb begin
    sticky_d      = sticky_q;
    runCnt_d      = runCnt_q;
    frameDone_d   = frameClose;
    frameMotion_d = frameMotion_q;
    alarm_d       = alarm_q;
    frameCount_d  = frameCount_q;
    if (pipeOutValid && pipeOutDetect) begin
      sticky_d = motionNow;
    end
    if (frameClose) begin
      frameCount_d = frameCount_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
      if (pipeOutDetect) begin
        frameMotion_d = motionNow;
        sticky_d      = 1'b0;
        if (motionNow) begin
          runCnt_d = (runCnt_q == 4'd15) ? 4'd15 : runCnt_q + 4'd1;
        end else begin
          runCnt_d = 4'd0;
        end
      end
      alarm_d = (cfg_alarm_frames != 4'd0) && (runCnt_d >= cfg_alarm_frames);
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      stopPending_q <= 1'b0;
      bgAge_q       <= 8'd0;
      thrShadow_q   <= DEFAULT_THRESHOLD;
      sticky_q      <= 1'b0;
      runCnt_q      <= 4'd0;
      frameDone_q   <= 1'b0;
      frameMotion_q <= 1'b0;
      alarm_q       <= 1'b0;
      frameCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      stopPending_q <= stopPending_d;
      bgAge_q       <= bgAge_d;
      thrShadow_q   <= thrShadow_d;
      sticky_q      <= sticky_d;
      runCnt_q      <= runCnt_d;
      frameDone_q   <= frameDone_d;
      frameMotion_q <= frameMotion_d;
      alarm_q       <= alarm_d;
      frameCount_q  <= frameCount_d;
    end
  end

  // Delay pipe shift, loaded with a bubble whenever nothing is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipeValid_q  <= '0;
      pipeLast_q   <= '0;
      pipeDetect_q <= '0;
    end else begin
      pipeValid_q[0]  <= mmg_enable;
      pipeLast_q[0]   <= mmg_last_in_frame;
      pipeDetect_q[0] <= mmg_enable & (state_q == ST_DETECT);
      for (int i = 1; i < MMG_LAT; i++) begin
        pipeValid_q[i]  <= pipeValid_q[i-1];
        pipeLast_q[i]   <= pipeLast_q[i-1];
        pipeDetect_q[i] <= pipeDetect_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mmg_frame_ctrl.sv
// tb_mmg_frame_ctrl: directed bench for mmg_frame_ctrl with MMG_LAT=2.
// A two-stage motion delay stands in for the generator's response latency.
module tb_mmg_frame_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  cfg_threshold;
  logic [7:0]  cfg_bg_period;
  logic [3:0]  cfg_alarm_frames;
  logic        s_valid;
  logic [31:0] s_pixel;
  logic        s_last;
  logic        mmg_enable;
  logic [31:0] mmg_pixel;
  logic        mmg_last_in_frame;
  logic        mmg_wr_background;
  logic [7:0]  mmg_threshold;
  logic        mmg_motion_detected;
  logic        frame_done;
  logic        frame_motion;
  logic        alarm;
  logic [15:0] frame_count;
  logic        busy;

  int checks;
  int failures;
  int doneSeen;
  int doneSnap;
  logic pixMotion;
  logic mdel0;
  logic mdel1;

  mmg_frame_ctrl #(
    .MMG_LAT(2),
    .DEFAULT_THRESHOLD(8'd20),
    .FRAME_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cfg_threshold(cfg_threshold),
    .cfg_bg_period(cfg_bg_period),
    .cfg_alarm_frames(cfg_alarm_frames),
    .s_valid(s_valid),
    .s_pixel(s_pixel),
    .s_last(s_last),
    .mmg_enable(mmg_enable),
    .mmg_pixel(mmg_pixel),
    .mmg_last_in_frame(mmg_last_in_frame),
    .mmg_wr_background(mmg_wr_background),
    .mmg_threshold(mmg_threshold),
    .mmg_motion_detected(mmg_motion_detected),
    .frame_done(frame_done),
    .frame_motion(frame_motion),
    .alarm(alarm),
    .frame_count(frame_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) doneSeen++;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and model the generator's motion latency.
  task automatic tick();
    @(posedge clk);
    #1;
    mdel1 = mdel0;
    mdel0 = pixMotion;
    mmg_motion_detected = mdel1;
  endtask

  task automatic idleCycle();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    pixMotion = 1'b0;
    tick();
  endtask

  task automatic sendPixel(input logic [31:0] pix, input logic last, input logic motion,
                           input logic expEn, input logic expWr, input logic [7:0] expThr);
    s_valid   = 1'b1;
    s_pixel   = pix;
    s_last    = last;
    pixMotion = motion;
    #1;
    check("mmg_enable", {31'd0, mmg_enable}, {31'd0, expEn});
    check("mmg_wr_background", {31'd0, mmg_wr_background}, {31'd0, expWr});
    check("mmg_last_in_frame", {31'd0, mmg_last_in_frame}, {31'd0, last & expEn});
    check("mmg_pixel", mmg_pixel, pix);
    check("mmg_threshold", {24'd0, mmg_threshold}, {24'd0, expThr});
    tick();
  endtask

  task automatic sendFrame(input int n, input int motionAt, input logic expWr, input logic [7:0] expThr);
    for (int i = 0; i < n; i++) begin
      sendPixel(32'hC0DE_0000 + i, (i == n - 1), (i == motionAt), 1'b1, expWr, expThr);
    end
    repeat (3) idleCycle();
  endtask

  initial begin
    checks = 0; failures = 0; doneSeen = 0; doneSnap = 0;
    pixMotion = 1'b0; mdel0 = 1'b0; mdel1 = 1'b0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_threshold = 8'd20; cfg_bg_period = 8'd0; cfg_alarm_frames = 4'd0;
    s_valid = 1'b0; s_pixel = 32'd0; s_last = 1'b0; mmg_motion_detected = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_motion", {31'd0, frame_motion}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_threshold", {24'd0, mmg_threshold}, 32'd20);
    check("rst_enable", {31'd0, mmg_enable}, 32'd0);
    rst = 1'b0;
    idleCycle();

    // Start, junk partial frame, then learn + two detect frames
    $display("[TB] basic learn/detect sequencing");
    start = 1'b1; idleCycle(); start = 1'b0;
    check("sync_busy", {31'd0, busy}, 32'd1);
    sendPixel(32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd20);
    sendPixel(32'h1111_0001, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
    sendFrame(4, -1, 1'b1, 8'd20);
    sendFrame(4, -1, 1'b0, 8'd20);
    sendFrame(4, -1, 1'b0, 8'd20);
    check("t1_done_pulses", doneSeen, 32'd3);
    check("t1_frame_count", {16'd0, frame_count}, 32'd3);
    check("t1_frame_motion", {31'd0, frame_motion}, 32'd0);

    // Alarm debounce over two motion frames
    $display("[TB] alarm debounce");
    cfg_alarm_frames = 4'd2;
    sendFrame(4, 2, 1'b0, 8'd20);
    check("t2a_frame_motion", {31'd0, frame_motion}, 32'd1);
    check("t2a_alarm", {31'd0, alarm}, 32'd0);
    sendFrame(4, 2, 1'b0, 8'd20);
    check("t2b_frame_motion", {31'd0, frame_motion}, 32'd1);
    check("t2b_alarm", {31'd0, alarm}, 32'd1);
    sendFrame(4, -1, 1'b0, 8'd20);
    check("t2c_frame_motion", {31'd0, frame_motion}, 32'd0);
    check("t2c_alarm", {31'd0, alarm}, 32'd0);
    check("t2_frame_count", {16'd0, frame_count}, 32'd6);

    // Stop in the middle of a detect frame
    $display("[TB] stop mid-detect");
    sendPixel(32'h2222_0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20);
    stop = 1'b1;
    sendPixel(32'h2222_0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20);
    stop = 1'b0;
    sendPixel(32'h2222_0002, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20);
    sendPixel(32'h2222_0003, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20);
    check("stop_done_e0", {31'd0, frame_done}, 32'd0);
    idleCycle();
    check("stop_done_e1", {31'd0, frame_done}, 32'd0);
    check("stop_busy_e1", {31'd0, busy}, 32'd1);
    idleCycle();
    check("stop_done_e2", {31'd0, frame_done}, 32'd1);
    check("stop_busy_e2", {31'd0, busy}, 32'd0);
    check("stop_frame_count", {16'd0, frame_count}, 32'd7);
    idleCycle();
    check("stop_done_e3", {31'd0, frame_done}, 32'd0);
    sendPixel(32'h2222_0004, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);

    // Same-cycle start and stop in IDLE
    $display("[TB] start+stop in idle");
    start = 1'b1; stop = 1'b1; idleCycle(); start = 1'b0; stop = 1'b0;
    check("ss_busy", {31'd0, busy}, 32'd0);
    sendPixel(32'h3333_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
    check("ss_busy_after", {31'd0, busy}, 32'd0);

    // Background refresh every two detect frames, mid-frame threshold change
    $display("[TB] background refresh and threshold");
    cfg_bg_period = 8'd2; cfg_alarm_frames = 4'd0;
    start = 1'b1; idleCycle(); start = 1'b0;
    sendPixel(32'h4444_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
    sendFrame(3, -1, 1'b1, 8'd20);
    sendPixel(32'h4444_0001, 1'b0, 1'b1, 1'b1, 1'b0, 8'd20);
    cfg_threshold = 8'd50;
    sendPixel(32'h4444_0002, 1'b0, 1'b0, 1'b1, 1'b0, 8'd20);
    sendPixel(32'h4444_0003, 1'b1, 1'b0, 1'b1, 1'b0, 8'd20);
    check("thr_after_last", {24'd0, mmg_threshold}, 32'd50);
    repeat (3) idleCycle();
    check("d1_frame_motion", {31'd0, frame_motion}, 32'd1);
    check("d1_alarm", {31'd0, alarm}, 32'd0);
    sendFrame(3, -1, 1'b0, 8'd50);
    check("d2_frame_motion", {31'd0, frame_motion}, 32'd0);
    sendFrame(3, 1, 1'b1, 8'd50);
    check("l2_frame_motion", {31'd0, frame_motion}, 32'd0);
    sendFrame(3, -1, 1'b0, 8'd50);
    check("d3_frame_motion", {31'd0, frame_motion}, 32'd0);
    check("bg_frame_count", {16'd0, frame_count}, 32'd12);
    sendFrame(3, 0, 1'b0, 8'd50);
    check("d4_frame_motion", {31'd0, frame_motion}, 32'd1);
    check("d4_frame_count", {16'd0, frame_count}, 32'd13);

    // Reset in the middle of a learn frame
    $display("[TB] reset mid-learn");
    sendPixel(32'h5555_0000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd50);
    sendPixel(32'h5555_0001, 1'b0, 1'b0, 1'b1, 1'b1, 8'd50);
    doneSnap = doneSeen;
    s_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("mr_frame_done", {31'd0, frame_done}, 32'd0);
    check("mr_frame_count", {16'd0, frame_count}, 32'd0);
    check("mr_frame_motion", {31'd0, frame_motion}, 32'd0);
    check("mr_alarm", {31'd0, alarm}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_threshold", {24'd0, mmg_threshold}, 32'd20);
    sendPixel(32'h5555_0002, 1'b1, 1'b0, 1'b0, 1'b0, 8'd20);
    repeat (3) idleCycle();
    check("mr_no_done", doneSeen, doneSnap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
